float_argmax_stream: RTL and testbench



---
 rtl/float_argmax_stream.sv | 174 +++++++++++++++++
 tb/tb_float_argmax_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/float_argmax_stream.sv
// float_argmax_stream
//   Streaming argmax over vectors of N IEEE-754 single-precision scores.
//   Scores arrive one per in_valid/in_ready handshake. The unit keeps the
//   running maximum and its position, then holds the winner on
//   out_valid/out_ready until downstream takes it.
//
//   Ordering is the bit-pattern float order: +0 > -0, and ties keep the
//   lowest index. With no macro defined, NaNs get no special treatment.
//
//   Optional feature, macro ARGMAX_NAN_FILTER_EN:
//     - NaN scores are consumed but never become the maximum.
//     - If every score in a vector is NaN, the result is index 0 with
//       value 0x7FC00000.
//
// Ports:
//   clk        clock; every state update happens on the rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the vector being accumulated
//              (ignored while a result is waiting)
//   in_valid   score valid
//   in_ready   unit can accept a score
//   in_data    score, IEEE-754 single
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_index  position (0..N-1) of the maximum within the vector
//   out_value  maximum score
//   busy       a vector is partly accumulated, or a result is not yet taken
module float_argmax_stream #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [31:0]      out_value,
  output logic             busy
);

  localparam int DATA_W = 32;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  count;
  logic [DATA_W-1:0] max_val;
  logic [IDX_W-1:0]  max_idx;

  logic              accept;
  logic              last;
  logic              take;
  logic [DATA_W-1:0] new_val;
  logic [IDX_W-1:0]  new_idx;
  logic [DATA_W-1:0] fin_val;
  logic [IDX_W-1:0]  fin_idx;

  // A >= B in the float bit-pattern order. Within one sign, bits [30:0]
  // (exponent above mantissa) compare as an unsigned magnitude. For
  // negative numbers the larger magnitude is the smaller value, so the
  // magnitude result is reversed.
  function automatic logic f_ge(input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b);
    if (a == b)
      return 1'b1;
    else if (a[31] != b[31])
      return ~a[31];
    else if (!a[31])
      return a[30:0] >= b[30:0];
    else
      return b[30:0] >= a[30:0];
  endfunction

`ifdef ARGMAX_NAN_FILTER_EN
  logic have_max;
  logic eff_have;
  logic new_have;
  logic x_nan;

  function automatic logic f_is_nan(input logic [DATA_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction
`endif

  // A score is taken only in ACCUM; clear wins over a coincident handshake.
  assign accept = (state == ACCUM) && in_valid && !clear;
  assign last   = (count == IDX_W'(N - 1));
  assign busy   = (count != '0) || (state == DONE);

  // Running-max candidate for the score currently on in_data.
  always_comb begin
`ifdef ARGMAX_NAN_FILTER_EN
    x_nan    = f_is_nan(in_data);
    // Position 0 starts a new vector, so any earlier maximum is stale.
    eff_have = (count != '0) && have_max;
    take     = !x_nan && (!eff_have || !f_ge(max_val, in_data));
    new_have = eff_have || !x_nan;
`else
    take     = (count == '0) || !f_ge(max_val, in_data);
`endif
    new_val = take ? in_data : max_val;
    new_idx = take ? count   : max_idx;
    fin_val = new_val;
    fin_idx = new_idx;
`ifdef ARGMAX_NAN_FILTER_EN
    if (!new_have) begin
      fin_val = 32'h7FC0_0000;
      fin_idx = '0;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && last) state_nxt = DONE;
      DONE:  if (out_ready)      state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end

  // Position counter and the result registers. The result holds until the
  // next vector completes, so it stays visible while the next vector is
  // being accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      out_index <= '0;
      out_value <= '0;
`ifdef ARGMAX_NAN_FILTER_EN
      have_max  <= 1'b0;
`endif
    end else if (state == ACCUM) begin
      if (clear) begin
        count <= '0;
      end else if (accept) begin
        count <= last ? '0 : count + IDX_W'(1);
`ifdef ARGMAX_NAN_FILTER_EN
        have_max <= new_have;
`endif
        if (last) begin
          out_index <= fin_idx;
          out_value <= fin_val;
        end
      end
    end
  end

  // Running maximum. It is reloaded at position 0, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      max_val <= new_val;
      max_idx <= new_idx;
    end
  end

endmodule

// File: tb/tb_float_argmax_stream.sv
module tb_float_argmax_stream;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [31:0]      out_value;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  float_argmax_stream #(.N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Feed one score per cycle with no gaps. Afterwards the result must be
  // presented and held.
  task automatic run_vec(input string tag,
                         input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3,
                         input int ei, input logic [31:0] ev);
    logic [31:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid_early"}, out_valid, 0);
      in_valid = 1'b1;
      in_data  = v[i];
      tick;
    end
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_in_ready_done"}, in_ready, 0);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_index"}, 32'(out_index), 32'(ei));
    check({tag, "_value"}, out_value, ev);
  endtask

  task automatic take_result(input string tag, input int ei, input logic [31:0] ev);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, "_take_out_valid"}, out_valid, 0);
    check({tag, "_take_in_ready"}, in_ready, 1);
    check({tag, "_take_busy"}, busy, 0);
    check({tag, "_hold_index"}, 32'(out_index), 32'(ei));
    check({tag, "_hold_value"}, out_value, ev);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_index", 32'(out_index), 0);
    check("rst_value", out_value, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick;

    // Mixed signs: 2.0 at position 1 wins.
    run_vec("mixed", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000,
            1, 32'h4000_0000);
    take_result("mixed", 1, 32'h4000_0000);

    // All negative: -1 at position 1; the tie at -3 does not matter.
    run_vec("neg", 32'hC040_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC040_0000,
            1, 32'hBF80_0000);
    take_result("neg", 1, 32'hBF80_0000);

    // Signed zeros: +0 beats -0, and the later +0 tie keeps index 1.
    run_vec("zeros", 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000,
            1, 32'h0000_0000);
    take_result("zeros", 1, 32'h0000_0000);

    // Backpressure: result held; input pulses and clear are ignored in DONE.
    run_vec("bp", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000,
            1, 32'h4000_0000);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_data  = 32'h7F7F_FFFF;
      clear    = (k == 2);
      tick;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_index", 32'(out_index), 1);
      check("bp_value", out_value, 32'h4000_0000);
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    take_result("bp", 1, 32'h4000_0000);
    // If the ignored pulses had been counted, this vector would end early.
    run_vec("post_bp", 32'hC040_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC040_0000,
            1, 32'hBF80_0000);
    take_result("post_bp", 1, 32'hBF80_0000);

    // Clear after two scores, with a coincident score that must be dropped.
    in_valid = 1'b1;
    in_data  = 32'h7F00_0000;
    tick;
    in_data  = 32'h7E00_0000;
    tick;
    check("clr_busy_before", busy, 1);
    clear    = 1'b1;
    in_data  = 32'h7F7F_FFFF;
    tick;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_busy_after", busy, 0);
    check("clr_out_valid", out_valid, 0);
    run_vec("clr", 32'h3F00_0000, 32'h4040_0000, 32'h3F80_0000, 32'h0000_0000,
            1, 32'h4040_0000);
    take_result("clr", 1, 32'h4040_0000);

    // Asynchronous reset in the middle of a vector.
    in_valid = 1'b1;
    in_data  = 32'h4100_0000;
    tick;
    tick;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    check("arst_out_valid", out_valid, 0);
    check("arst_index", 32'(out_index), 0);
    check("arst_value", out_value, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    tick;
    rst_n = 1'b1;
    tick;
    check("arst_no_result", out_valid, 0);
    run_vec("post_rst", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000,
            1, 32'h4000_0000);
    take_result("post_rst", 1, 32'h4000_0000);

    // Asynchronous reset while a result is waiting: no result is emitted.
    run_vec("done_rst", 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000,
            1, 32'h4000_0000);
    rst_n = 1'b0;
    #2;
    check("done_rst_out_valid", out_valid, 0);
    check("done_rst_value", out_value, 0);
    check("done_rst_busy", busy, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // NaN handling.
`ifdef ARGMAX_NAN_FILTER_EN
    run_vec("nan_mix", 32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0001, 32'h3F00_0000,
            1, 32'h3F80_0000);
    take_result("nan_mix", 1, 32'h3F80_0000);
`else
    // In plain bit-pattern order, 0x7FC00000 is the largest score here.
    run_vec("nan_mix", 32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0001, 32'h3F00_0000,
            0, 32'h7FC0_0000);
    take_result("nan_mix", 0, 32'h7FC0_0000);
`endif
    run_vec("nan_all", 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
            0, 32'h7FC0_0000);
    take_result("nan_all", 0, 32'h7FC0_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
